pipeline_ctrl: RTL and testbench

- Central hazard and exception controller for the 5-stage MIPS core.
- Drives the stall vector and flush line consumed by every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB), and the redirect PC handed to IF.
- Collects stall requests from the stages, and exception / ERET events from MEM.
- Sequences the flush and then the PC redirect handshake with the fetch unit.

---
 rtl/pipeline_ctrl.sv | 109 ++++++++++
 tb/tb_pipeline_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/exception controller: stall vector, flush, and PC redirect handshake to IF.
// Latency: stall/flush/commit combinational same cycle; redirect offered the cycle after the event.
// Backpressure: redirect held (PC stalled) until if_ready_i; optional counters under PIPE_CTRL_PERF_CNT_EN.
module pipeline_ctrl #(
   parameter int                ADDR_W     = 32,
   parameter int                EXC_W      = 8,
   parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'hBFC00380,
   parameter int                CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_req_if,
   input  logic              stall_req_id,
   input  logic              stall_req_ex,
   input  logic              stall_req_mem,
   input  logic [EXC_W-1:0]  exception_type_i,
   input  logic              eret_i,
   input  logic [ADDR_W-1:0] cp0_epc_i,
   input  logic              if_ready_i,
   output logic [5:0]        stall_o,
   output logic              flush_o,
   output logic              exc_commit_o,
   output logic              redirect_valid_o,
   output logic [ADDR_W-1:0] redirect_pc_o,
   output logic [CNT_W-1:0]  stall_cycles_o,
   output logic [CNT_W-1:0]  flush_count_o
);

   typedef enum logic {
      RUN      = 1'b0,
      REDIRECT = 1'b1
   } state_t;

   state_t state;
   logic   exc_evt;

   assign exc_evt = (exception_type_i != '0) | eret_i;

   // Stall/flush decode; reset forces everything low without waiting for a clock edge.
   always_comb begin
      stall_o      = 6'b000000;
      flush_o      = 1'b0;
      exc_commit_o = 1'b0;
      if (rst) begin
         if (state == REDIRECT) begin
            // pipeline is empty after the flush; only the PC is held
            stall_o = 6'b000001;
         end else if (exc_evt) begin
            flush_o      = 1'b1;
            exc_commit_o = 1'b1;
         end else if (stall_req_mem) begin
            stall_o = 6'b011111;
         end else if (stall_req_ex) begin
            stall_o = 6'b001111;
         end else if (stall_req_id) begin
            stall_o = 6'b000111;
         end else if (stall_req_if) begin
            stall_o = 6'b000011;
         end
      end
   end

   // Control FSM with registered redirect outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= RUN;
         redirect_valid_o <= 1'b0;
         redirect_pc_o    <= '0;
      end else begin
         case (state)
            RUN: begin
               if (exc_evt) begin
                  state            <= REDIRECT;
                  redirect_valid_o <= 1'b1;
                  // a real exception takes priority over a simultaneous ERET
                  redirect_pc_o    <= (exception_type_i != '0) ? EXC_VECTOR : cp0_epc_i;
               end
            end
            REDIRECT: begin
               if (if_ready_i) begin
                  state            <= RUN;
                  redirect_valid_o <= 1'b0;
               end
            end
            default: begin
               state            <= RUN;
               redirect_valid_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef PIPE_CTRL_PERF_CNT_EN
   // Free-running stall-cycle and flush counters, wrapping naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_o <= '0;
         flush_count_o  <= '0;
      end else begin
         if (stall_o != 6'b000000) stall_cycles_o <= stall_cycles_o + 1'b1;
         if (flush_o)              flush_count_o  <= flush_count_o + 1'b1;
      end
   end
`else
   assign stall_cycles_o = '0;
   assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized + directed bench for pipeline_ctrl with a queue-based reference model.
// Stimulus pushes expected per-cycle outputs; a negedge monitor pops and compares.
// Counter expectations follow PIPE_CTRL_PERF_CNT_EN when defined, else zero.
module tb_pipeline_ctrl;

   localparam logic [31:0] EXC_VEC = 32'hBFC00380;

   logic        clk;
   logic        rst;
   logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
   logic [7:0]  exception_type_i;
   logic        eret_i;
   logic [31:0] cp0_epc_i;
   logic        if_ready_i;
   logic [5:0]  stall_o;
   logic        flush_o, exc_commit_o, redirect_valid_o;
   logic [31:0] redirect_pc_o, stall_cycles_o, flush_count_o;

   pipeline_ctrl dut (
      .clk(clk), .rst(rst),
      .stall_req_if(stall_req_if), .stall_req_id(stall_req_id),
      .stall_req_ex(stall_req_ex), .stall_req_mem(stall_req_mem),
      .exception_type_i(exception_type_i), .eret_i(eret_i),
      .cp0_epc_i(cp0_epc_i), .if_ready_i(if_ready_i),
      .stall_o(stall_o), .flush_o(flush_o), .exc_commit_o(exc_commit_o),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
      .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic        commit;
      logic        rv;
      logic        chk_pc;
      logic [31:0] rpc;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] pending[$];   // outstanding redirect targets (non-empty == redirecting)
   logic [31:0] m_sc, m_fc;
   int          n_chk = 0;
   int          n_err = 0;
   bit          perf_en;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One stimulus cycle: apply inputs after the edge, predict, push, advance the model.
   task automatic cyc(input bit r, input logic [3:0] req, input logic [7:0] et,
                      input bit er, input logic [31:0] epc, input bit rdy);
      exp_t e;
      int   depth;
      @(posedge clk);
      #1;
      rst = r;
      {stall_req_mem, stall_req_ex, stall_req_id, stall_req_if} = req;
      exception_type_i = et;
      eret_i = er;
      cp0_epc_i = epc;
      if_ready_i = rdy;
      e = '{stall: 6'd0, flush: 1'b0, commit: 1'b0, rv: 1'b0, chk_pc: 1'b0,
            rpc: 32'd0, sc: 32'd0, fc: 32'd0};
      if (!r) begin
         pending.delete();
         m_sc = 0;
         m_fc = 0;
         e.chk_pc = 1'b1;
         sb.push_back(e);
         return;
      end
      e.sc = m_sc;
      e.fc = m_fc;
      if (pending.size() > 0) begin
         e.stall  = 6'b000001;
         e.rv     = 1'b1;
         e.chk_pc = 1'b1;
         e.rpc    = pending[0];
      end else if (et != 0 || er) begin
         e.flush  = 1'b1;
         e.commit = 1'b1;
      end else begin
         depth = req[3] ? 4 : req[2] ? 3 : req[1] ? 2 : req[0] ? 1 : 0;
         e.stall = (depth == 0) ? 6'd0 : 6'((1 << (depth + 1)) - 1);
      end
      sb.push_back(e);
      if (perf_en) begin
         if (e.stall != 0) m_sc++;
         if (e.flush)      m_fc++;
      end
      if (pending.size() > 0) begin
         if (rdy) void'(pending.pop_front());
      end else if (et != 0 || er) begin
         pending.push_back((et != 0) ? EXC_VEC : epc);
      end
   endtask

   // Monitor: outputs are presented every cycle; compare at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stall_o",          {26'd0, stall_o},  {26'd0, e.stall});
            chk("flush_o",          {31'd0, flush_o},  {31'd0, e.flush});
            chk("exc_commit_o",     {31'd0, exc_commit_o}, {31'd0, e.commit});
            chk("redirect_valid_o", {31'd0, redirect_valid_o}, {31'd0, e.rv});
            if (e.chk_pc) chk("redirect_pc_o", redirect_pc_o, e.rpc);
            chk("stall_cycles_o",   stall_cycles_o, e.sc);
            chk("flush_count_o",    flush_count_o,  e.fc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef PIPE_CTRL_PERF_CNT_EN
      perf_en = 1'b1;
`else
      perf_en = 1'b0;
`endif
      m_sc = 0; m_fc = 0;
      rst = 1'b0;
      {stall_req_mem, stall_req_ex, stall_req_id, stall_req_if} = 4'b0;
      exception_type_i = 8'h00; eret_i = 1'b0; cp0_epc_i = 32'h0; if_ready_i = 1'b0;

      // reset with requests active
      cyc(1'b0, 4'b1111, 8'h00, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 4'b0000, 8'h00, 1'b0, 32'h0, 1'b0);
      // stall priority
      cyc(1'b1, 4'b0010, 8'h00, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 4'b1010, 8'h00, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 4'b0001, 8'h00, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 4'b0100, 8'h00, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 4'b0000, 8'h00, 1'b0, 32'h0, 1'b0);
      // exception overriding a mem stall
      cyc(1'b1, 4'b1000, 8'h0C, 1'b0, 32'h8000_1234, 1'b0);
      cyc(1'b1, 4'b0000, 8'h00, 1'b0, 32'h0, 1'b1);
      // ERET with IF backpressure, then isolation of events inside REDIRECT
      cyc(1'b1, 4'b0000, 8'h00, 1'b1, 32'h8000_1234, 1'b0);
      cyc(1'b1, 4'b0000, 8'h00, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 4'b0100, 8'h05, 1'b1, 32'h1111_0000, 1'b0);
      cyc(1'b1, 4'b0000, 8'h00, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 4'b0000, 8'h00, 1'b0, 32'h0, 1'b1);
      // back-to-back exception right after returning to RUN; exception beats ERET
      cyc(1'b1, 4'b0000, 8'h01, 1'b1, 32'h2222_0000, 1'b1);
      cyc(1'b1, 4'b0000, 8'h00, 1'b0, 32'h0, 1'b1);
      cyc(1'b1, 4'b0000, 8'h00, 1'b0, 32'h0, 1'b0);
      // reset while redirecting discards the redirect
      cyc(1'b1, 4'b0000, 8'h00, 1'b1, 32'h3333_0000, 1'b0);
      cyc(1'b1, 4'b0000, 8'h00, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 4'b0000, 8'h00, 1'b0, 32'h0, 1'b0);
      #1;
      chk("reset_async_valid", {31'd0, redirect_valid_o}, 32'd0);
      // counter scenario: 5 stalls, exception, 2 redirect cycles
      cyc(1'b1, 4'b0001, 8'h00, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 4'b0010, 8'h00, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 4'b0100, 8'h00, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 4'b1000, 8'h00, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 4'b0011, 8'h00, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 4'b0000, 8'h0C, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 4'b0000, 8'h00, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 4'b0000, 8'h00, 1'b0, 32'h0, 1'b1);
      cyc(1'b1, 4'b0000, 8'h00, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      #1;
      chk("perf_stall_cycles", stall_cycles_o, perf_en ? 32'd7 : 32'd0);
      chk("perf_flush_count",  flush_count_o,  perf_en ? 32'd1 : 32'd0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [7:0] et;
         et = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         cyc(($urandom_range(0, 79) != 0),
             4'($urandom),
             et,
             ($urandom_range(0, 9) == 0),
             $urandom,
             ($urandom_range(0, 1) == 1));
      end

      repeat (4) @(negedge clk);
      #1;
      n_chk++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
